fpu_seq: RTL

FPU_SEQ -- requirements
Module: fpu_seq

---
 rtl/fpu_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fpu_seq.sv
// Request queue and sequencer that feeds one operation at a time to an external FPU and holds each result until the consumer takes it.
// Optional WAIT-state timeout is enabled with the FPU_SEQ_TIMEOUT_EN macro.
module fpu_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [1:0]  fpu_funct,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_start,
    input  logic [31:0] fpu_o,
    input  logic        fpu_finish,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_funct,
    output logic [31:0] rsp_o,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t        state, state_n;
    logic [1:0]    q_funct [DEPTH];
    logic [31:0]   q_a     [DEPTH];
    logic [31:0]   q_b     [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, timeout;

    assign req_ready = (count < (AW+1)'(DEPTH));
    assign push      = req_valid && req_ready;
    assign fpu_start = (state == S_ISSUE);
    assign busy      = (state != S_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_funct[wr_ptr] <= req_funct;
            q_a[wr_ptr]     <= req_a;
            q_b[wr_ptr]     <= req_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (fpu_finish || timeout) state_n = S_HOLD;
            S_HOLD:  if (rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operand registers stay put from ISSUE until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_funct <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
        end else if (pop) begin
            fpu_funct <= q_funct[rd_ptr];
            fpu_a     <= q_a[rd_ptr];
            fpu_b     <= q_b[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_funct <= '0;
            rsp_o     <= '0;
        end else if (state == S_WAIT && fpu_finish) begin
            rsp_valid <= 1'b1;
            rsp_funct <= fpu_funct;
            rsp_o     <= fpu_o;
        end else if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_funct <= fpu_funct;
            rsp_o     <= 32'h7FC0_0000;
        end else if (state == S_HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wcnt;
    logic          rsp_err_q;

    // A finish on the last counted cycle still wins over the timeout.
    assign timeout = (state == S_WAIT) && !fpu_finish && (wcnt == CW'(TIMEOUT - 1));
    assign rsp_err = rsp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wcnt <= '0;
        else if (state != S_WAIT) wcnt <= '0;
        else                      wcnt <= wcnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   rsp_err_q <= 1'b0;
        else if (state == S_WAIT && fpu_finish)    rsp_err_q <= 1'b0;
        else if (timeout)                          rsp_err_q <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule
